// File: rtl/qmult_pipe_if.sv
// Streaming handshake and data bundle for the pipelined Q-format multiplier.
interface qmult_pipe_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_multiplicand;
  logic [N-1:0] i_multiplier;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic         o_ovr;
  logic         o_ovr_sticky;
  logic         i_clr_ovr;

  modport slave (
    input  i_valid, i_multiplicand, i_multiplier, i_ready, i_clr_ovr,
    output o_ready, o_valid, o_result, o_ovr, o_ovr_sticky
  );

  modport master (
    output i_valid, i_multiplicand, i_multiplier, i_ready, i_clr_ovr,
    input  o_ready, o_valid, o_result, o_ovr, o_ovr_sticky
  );
endinterface

// File: rtl/qmult_pipe.sv
// Three-stage signed Q(N,Q) multiplier: operand register, full product, round/saturate.
// A single global stall freezes every stage while the output is held.
module qmult_pipe #(
  parameter int N   = 32,
  parameter int Q   = 22,
  parameter int RND = 0,
  parameter int SAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  qmult_pipe_if.slave bus
);
  localparam int STAGES = 3;
  // Rounding constant sized one bit wider than the product so the add never wraps.
  localparam logic [2*N:0] RND_C = (RND != 0) ? ((2*N+1)'(1) << (Q-1)) : '0;

  logic                  stall;
  logic [STAGES:1]       vld_pipe_q;
  logic signed [N-1:0]   a_q, b_q;
  logic signed [2*N-1:0] prod_d, prod_q;
  logic signed [2*N:0]   r_c, s_c;
  logic [N+1:0]          hi_c;
  logic                  ovr_d, ovr_q;
  logic [N-1:0]          res_d, res_q;
  logic                  sticky_d, sticky_q;

  assign stall       = vld_pipe_q[STAGES] & ~bus.i_ready;
  assign bus.o_ready = ~stall;

  always_comb begin
    prod_d = (2*N)'(a_q) * (2*N)'(b_q);
    r_c    = $signed({prod_q[2*N-1], prod_q}) + $signed(RND_C);
    s_c    = r_c >>> Q;
    // Fits in N bits only if every bit from the result sign upward agrees.
    hi_c   = s_c[2*N:N-1];
    ovr_d  = ~(&hi_c) & (|hi_c);
    res_d  = s_c[N-1:0];
    if (ovr_d && (SAT != 0))
      res_d = s_c[2*N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end

  // Set from a transferred overflow takes priority over a same-cycle clear.
  assign sticky_d = (vld_pipe_q[STAGES] & bus.i_ready & ovr_q) |
                    (sticky_q & ~bus.i_clr_ovr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      res_q      <= '0;
      ovr_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      if (!stall) begin
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.i_valid};
        a_q        <= bus.i_multiplicand;
        b_q        <= bus.i_multiplier;
        prod_q     <= prod_d;
        res_q      <= res_d;
        ovr_q      <= ovr_d;
      end
      sticky_q <= sticky_d;
    end
  end

  assign bus.o_valid      = vld_pipe_q[STAGES];
  assign bus.o_result     = res_q;
  assign bus.o_ovr        = ovr_q;
  assign bus.o_ovr_sticky = sticky_q;
endmodule

// File: tb/tb_qmult_pipe.sv
// Runs four rounding/saturation variants in lockstep against a longint reference model.
module tb_qmult_pipe;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        vin = 1'b0, rdy_in = 1'b1, clr = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [3:0]  ovld, ordy, oovr, ostk;
  logic [3:0][31:0] ores;

  // Instance k: RND = k/2, SAT = 1 for even k.
  qmult_pipe_if #(.N(N)) ifs [4] ();
  for (genvar k = 0; k < 4; k++) begin : g_dut
    assign ifs[k].i_valid        = vin;
    assign ifs[k].i_multiplicand = a_in;
    assign ifs[k].i_multiplier   = b_in;
    assign ifs[k].i_ready        = rdy_in;
    assign ifs[k].i_clr_ovr      = clr;
    assign ovld[k] = ifs[k].o_valid;
    assign ordy[k] = ifs[k].o_ready;
    assign oovr[k] = ifs[k].o_ovr;
    assign ostk[k] = ifs[k].o_ovr_sticky;
    assign ores[k] = ifs[k].o_result;
    qmult_pipe #(.N(N), .Q(22), .RND(k/2), .SAT((k%2 == 0) ? 1 : 0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(ifs[k])
    );
  end

  typedef struct packed {
    logic [3:0][31:0] r;
    logic [3:0]       o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_err = 0, n_out = 0, base;
  bit   done = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   m;
    longint p, s;
    bit     ov;
    for (int k = 0; k < 4; k++) begin
      p = longint'($signed(a)) * longint'($signed(b));
      if (k / 2 == 1) p = p + (longint'(1) << 21);
      s  = p >>> 22;
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      m.o[k] = ov;
      if (ov && (k % 2 == 0)) m.r[k] = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
      else                    m.r[k] = s[31:0];
    end
    return m;
  endfunction

  function automatic logic [31:0] rv();
    logic [31:0] edges [5] = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h00400000};
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r;
      1:       return 32'($signed(r) >>> $urandom_range(4, 12));
      default: return edges[$urandom_range(0, 4)];
    endcase
  endfunction

  // Scoreboard: outputs compared first, then the cycle's input transfer is enqueued.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++)
        if (ovld[k] && !rdy_in) chk($sformatf("stall_rdy%0d", k), ordy[k], 1'b0);
      if (sb.size() == 0) chk("unexp_vld", ovld, 4'h0);
      else if (ovld[0]) begin
        e = sb[0];
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("vld%0d", k), ovld[k], 1'b1);
          chk($sformatf("res%0d", k), ores[k], e.r[k]);
          chk($sformatf("ovr%0d", k), oovr[k], e.o[k]);
        end
        if (rdy_in) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
      if (vin && ordy[0]) sb.push_back(model(a_in, b_in));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    bit acc = 0;
    a_in = a; b_in = b; vin = 1'b1;
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge clk);
      acc = ordy[0];
      @(posedge clk);
      #1;
    end
    chk("accept", acc, 1'b1);
    vin = 1'b0;
  endtask

  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0][31:0] r, input logic [3:0] o);
    int cyc = 1;
    drive(a, b);
    while (!ovld[0] && cyc < 10) begin
      step();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_res%0d", tag, k), ores[k], r[k]);
      chk($sformatf("%s_ovr%0d", tag, k), oovr[k], o[k]);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #9;
    chk("rst_vld", ovld, 4'h0);
    chk("rst_ovr", oovr, 4'h0);
    chk("rst_stk", ostk, 4'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_res%0d", k), ores[k], 32'h0);
    #12 rst_n = 1'b1;
    #1 chk("rel_rdy", ordy, 4'hF);
    step();

    single("mul15x2", 32'h00600000, 32'h00800000, {4{32'h00C00000}}, 4'h0);
    step();
    chk("stk_none", ostk, 4'h0);
    single("neg", 32'hFFC00000, 32'h00200000, {4{32'hFFE00000}}, 4'h0);
    step();

    base = n_out;
    for (int i = 0; i < 8; i++) drive(rv(), rv());
    step(6);
    chk("stream8", n_out - base, 8);

    single("ovf", 32'h40000000, 32'h00800000,
           {32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF}, 4'hF);
    step();
    chk("stk_set", ostk, 4'hF);
    clr = 1'b1; step(); clr = 1'b0;
    chk("stk_clr", ostk, 4'h0);

    single("minmin", 32'h80000000, 32'h80000000,
           {32'h0, 32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF}, 4'hF);
    clr = 1'b1; step(); clr = 1'b0;
    chk("stk_setwins", ostk, 4'hF);

    single("rnd_pos", 32'h00000001, 32'h00200000, {32'h1, 32'h1, 32'h0, 32'h0}, 4'h0);
    step();
    single("rnd_neg", 32'hFFFFFFFF, 32'h00200000,
           {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'h0);
    step();

    // Backpressure with three operations in flight.
    rdy_in = 1'b0;
    base = n_out;
    for (int i = 0; i < 3; i++) drive(rv(), rv());
    repeat (5) begin
      @(negedge clk);
      chk("bp_ordy", ordy, 4'h0);
      chk("bp_vld", ovld, 4'hF);
    end
    chk("bp_none_out", n_out - base, 0);
    @(posedge clk); #1 rdy_in = 1'b1;
    step(6);
    chk("bp_drain", n_out - base, 3);

    // Random traffic under random downstream readiness.
    base = n_out;
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) drive(rv(), rv());
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rdy_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rdy_in = 1'b1;
    step(8);
    chk("rand_drain", n_out - base, 40);
    chk("sb_empty", sb.size(), 0);

    // Reset with two operations in flight, the first already at the output.
    rdy_in = 1'b0;
    drive(rv(), rv());
    drive(rv(), rv());
    @(posedge clk); #2;
    chk("pre_rst_vld", ovld, 4'hF);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_vld", ovld, 4'h0);
    chk("mid_rst_stk", ostk, 4'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("mid_rst_res%0d", k), ores[k], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_in = 1'b1;
    #1 chk("post_rst_rdy", ordy, 4'hF);
    step(6);
    single("post_rst", 32'h00600000, 32'h00800000, {4{32'h00C00000}}, 4'h0);
    step(4);
    chk("final_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
